// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: sequences PLL reset, lock qualification and frequency check before releasing system reset
module pll_lock_supervisor #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 50000,
    parameter int STABLE_CYCLES  = 1024,
    parameter int WINDOW         = 1000,
    parameter int EXP_EDGES      = 100,
    parameter int TOL            = 2,
    parameter int MAX_RETRY      = 3
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       mon_clk,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fault,
    output logic [1:0] retry_cnt,
    output logic [2:0] state
);
    localparam logic [2:0] S_PLL_RST   = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_STABLE    = 3'd2;
    localparam logic [2:0] S_CHECK     = 3'd3;
    localparam logic [2:0] S_RUN       = 3'd4;
    localparam logic [2:0] S_FAULT     = 3'd5;
    localparam int MAX_A = PLL_RST_CYCLES > LOCK_TIMEOUT ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_B = STABLE_CYCLES > WINDOW ? STABLE_CYCLES : WINDOW;
    localparam int CW    = $clog2((MAX_A > MAX_B ? MAX_A : MAX_B) + 1);
    localparam int EW    = $clog2(WINDOW + 1);
    localparam logic [31:0] LO = 32'(EXP_EDGES > TOL ? EXP_EDGES - TOL : 0);
    localparam logic [31:0] HI = 32'(EXP_EDGES + TOL);
    localparam logic [31:0] MR = 32'(MAX_RETRY);

    logic          r_lk_s1, r_lk;
    logic [2:0]    r_mon;
    logic [2:0]    r_state, w_state_nx;
    logic [CW-1:0] r_cnt;
    logic [EW-1:0] r_edges, w_edges_fin;
    logic [1:0]    r_retry, w_retry_inc;
    logic          r_pll_rst, r_sys_rst, r_ready, r_fault;
    logic          w_pll_rst, w_sys_rst, w_ready, w_fault;
    logic          w_edge, w_in_tol, w_fail;

    assign w_edge      = r_mon[1] & ~r_mon[2];
    assign w_edges_fin = (r_edges == '1) ? r_edges : r_edges + EW'(w_edge);
    assign w_in_tol    = 32'(w_edges_fin) >= LO && 32'(w_edges_fin) <= HI;
    assign w_retry_inc = (r_retry == 2'd3) ? 2'd3 : r_retry + 2'd1;

    // synchronize the asynchronous lock flag and the monitored clock into refclk
    always_ff @(posedge refclk) begin
        if (rst) begin
            r_lk_s1 <= 1'b0;
            r_lk    <= 1'b0;
            r_mon   <= 3'd0;
        end else begin
            r_lk_s1 <= pll_locked;
            r_lk    <= r_lk_s1;
            r_mon   <= {r_mon[1:0], mon_clk};
        end
    end

    // state register, per-state cycle counter, window edge count, retry count and registered outputs
    always_ff @(posedge refclk) begin
        if (rst) begin
            r_state   <= S_PLL_RST;
            r_cnt     <= '0;
            r_edges   <= '0;
            r_retry   <= 2'd0;
            r_pll_rst <= 1'b1;
            r_sys_rst <= 1'b1;
            r_ready   <= 1'b0;
            r_fault   <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= (w_state_nx != r_state) ? '0 : r_cnt + CW'(1);
            r_edges   <= (r_state == S_CHECK && w_state_nx == S_CHECK) ? w_edges_fin : '0;
            r_retry   <= w_fail ? w_retry_inc : (w_state_nx == S_RUN && r_state != S_RUN) ? 2'd0 : r_retry;
            r_pll_rst <= w_pll_rst;
            r_sys_rst <= w_sys_rst;
            r_ready   <= w_ready;
            r_fault   <= w_fault;
        end
    end

    // next state; a lock seen on the timeout cycle wins, a lock loss on the window-end cycle fails
    always_comb begin
        w_fail     = 1'b0;
        w_state_nx = r_state;
        case (r_state)
            S_PLL_RST:   if (r_cnt == CW'(PLL_RST_CYCLES - 1)) w_state_nx = S_WAIT_LOCK;
            S_WAIT_LOCK: if (r_lk) w_state_nx = S_STABLE;
                         else if (r_cnt == CW'(LOCK_TIMEOUT - 1)) w_fail = 1'b1;
            S_STABLE:    if (!r_lk) w_state_nx = S_WAIT_LOCK;
                         else if (r_cnt == CW'(STABLE_CYCLES - 1)) w_state_nx = S_CHECK;
            S_CHECK:     if (!r_lk || (r_cnt == CW'(WINDOW - 1) && !w_in_tol)) w_fail = 1'b1;
                         else if (r_cnt == CW'(WINDOW - 1)) w_state_nx = S_RUN;
            S_RUN:       if (!r_lk) w_state_nx = S_PLL_RST;
            S_FAULT:     w_state_nx = S_FAULT;
            default:     w_state_nx = S_PLL_RST;
        endcase
        if (w_fail) w_state_nx = (32'(w_retry_inc) >= MR) ? S_FAULT : S_PLL_RST;
    end

    // outputs decoded from the next state so they register in step with it
    always_comb begin
        w_pll_rst = w_state_nx == S_PLL_RST || w_state_nx == S_FAULT;
        w_sys_rst = w_state_nx != S_RUN;
        w_ready   = w_state_nx == S_RUN;
        w_fault   = w_state_nx == S_FAULT;
    end

    assign pll_rst   = r_pll_rst;
    assign sys_rst   = r_sys_rst;
    assign ready     = r_ready;
    assign fault     = r_fault;
    assign retry_cnt = r_retry;
    assign state     = r_state;
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor: scenario tasks checked against timing and tolerance rules computed arithmetically
module tb_pll_lock_supervisor;
    localparam int RSTC = 16, TO = 400, SC = 64, WIN = 100, EXP = 10, TOL = 2, MR = 3;
    localparam int ACQ = RSTC + 1 + SC;

    logic       refclk, rst, pll_locked, mon_clk, pll_rst, sys_rst, ready, fault;
    logic [1:0] retry_cnt;
    logic [2:0] state;
    int checks = 0, failures = 0, acc = 0, mon_step = 0;

    pll_lock_supervisor #(
        .PLL_RST_CYCLES(RSTC), .LOCK_TIMEOUT(TO), .STABLE_CYCLES(SC), .WINDOW(WIN),
        .EXP_EDGES(EXP), .TOL(TOL), .MAX_RETRY(MR)
    ) dut (
        .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .mon_clk(mon_clk),
        .pll_rst(pll_rst), .sys_rst(sys_rst), .ready(ready), .fault(fault),
        .retry_cnt(retry_cnt), .state(state)
    );

    initial refclk = 1'b0;
    always #10 refclk = ~refclk;

    // phase accumulator: any WIN consecutive cycles contain exactly mon_step rising edges
    initial begin
        mon_clk = 1'b0;
        forever begin
            @(posedge refclk);
            #1;
            acc = acc + mon_step;
            if (acc >= WIN) acc = acc - WIN;
            mon_clk = acc < WIN / 2;
        end
    end

    function automatic logic [8:0] obs();
        return {state, pll_rst, sys_rst, ready, fault, retry_cnt};
    endfunction

    function automatic logic [8:0] expv(input logic [2:0] s, input logic [1:0] r);
        return {s, s == 3'd0 || s == 3'd5, s != 3'd4, s == 3'd4, s == 3'd5, r};
    endfunction

    task automatic tick();
        @(posedge refclk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, output int n);
        n = 0;
        while (state !== s && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_change(input int budget, output int n);
        logic [2:0] s0;
        s0 = state;
        n = 0;
        while (state === s0 && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pll_locked = 1'b0;
        mon_step = EXP;
        tick();
        checks++; if (obs() !== expv(3'd0, 2'd0)) begin failures++; $display("FAIL reset_state: got %b want %b", obs(), expv(3'd0, 2'd0)); end
        rst = 1'b0;
    endtask

    task automatic test_nominal();
        int n, d;
        d = int'($urandom_range(5, 300));
        pll_locked = 1'b0;
        mon_step = EXP - TOL + int'($urandom_range(0, 2 * TOL));
        do_reset();
        wait_state(3'd1, 100, n);
        checks++; if (n !== RSTC) begin failures++; $display("FAIL nom_pll_rst_len: got %0d want %0d", n, RSTC); end
        checks++; if (obs() !== expv(3'd1, 2'd0)) begin failures++; $display("FAIL nom_wait: got %b want %b", obs(), expv(3'd1, 2'd0)); end
        repeat (d) tick();
        pll_locked = 1'b1;
        wait_state(3'd2, 10, n);
        checks++; if (n !== 3) begin failures++; $display("FAIL nom_lock_latency: got %0d want %0d", n, 3); end
        wait_state(3'd3, SC + 10, n);
        checks++; if (n !== SC) begin failures++; $display("FAIL nom_stable_len: got %0d want %0d", n, SC); end
        wait_state(3'd4, WIN + 10, n);
        checks++; if (n !== WIN) begin failures++; $display("FAIL nom_check_len: got %0d want %0d", n, WIN); end
        checks++; if (obs() !== expv(3'd4, 2'd0)) begin failures++; $display("FAIL nom_run: got %b want %b", obs(), expv(3'd4, 2'd0)); end
        repeat (20) tick();
        checks++; if (obs() !== expv(3'd4, 2'd0)) begin failures++; $display("FAIL nom_run_hold: got %b want %b", obs(), expv(3'd4, 2'd0)); end
    endtask

    task automatic test_timeouts();
        int n;
        pll_locked = 1'b0;
        do_reset();
        for (int i = 1; i <= MR; i++) begin
            wait_state(3'd1, 100, n);
            checks++; if (n !== RSTC) begin failures++; $display("FAIL to_pll_rst_len[%0d]: got %0d want %0d", i, n, RSTC); end
            wait_change(TO + 10, n);
            checks++; if (n !== TO) begin failures++; $display("FAIL to_wait_len[%0d]: got %0d want %0d", i, n, TO); end
            checks++; if (obs() !== expv(i < MR ? 3'd0 : 3'd5, 2'(i))) begin failures++; $display("FAIL to_after[%0d]: got %b want %b", i, obs(), expv(i < MR ? 3'd0 : 3'd5, 2'(i))); end
        end
        pll_locked = 1'b1;
        repeat (300) tick();
        checks++; if (obs() !== expv(3'd5, 2'(MR))) begin failures++; $display("FAIL fault_sticky: got %b want %b", obs(), expv(3'd5, 2'(MR))); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (obs() !== expv(3'd0, 2'd0)) begin failures++; $display("FAIL fault_reset: got %b want %b", obs(), expv(3'd0, 2'd0)); end
    endtask

    task automatic test_lock_vs_timeout();
        int n;
        for (int late = 0; late < 2; late++) begin
            pll_locked = 1'b0;
            do_reset();
            wait_state(3'd1, 100, n);
            repeat (TO - 3 + late) tick();
            pll_locked = 1'b1;
            wait_change(10, n);
            checks++; if (n !== 3 - late) begin failures++; $display("FAIL lvt_latency[%0d]: got %0d want %0d", late, n, 3 - late); end
            checks++; if (obs() !== (late == 1 ? expv(3'd0, 2'd1) : expv(3'd2, 2'd0))) begin failures++; $display("FAIL lvt_state[%0d]: got %b want %b", late, obs(), late == 1 ? expv(3'd0, 2'd1) : expv(3'd2, 2'd0)); end
        end
    endtask

    task automatic test_freq();
        int n, s, d;
        int steps [8];
        logic ok;
        steps = '{EXP - TOL - 1, EXP - TOL, EXP + TOL, EXP + TOL + 1, 0,
                  EXP - TOL - 3 + int'($urandom_range(0, 2 * TOL + 6)),
                  EXP - TOL - 3 + int'($urandom_range(0, 2 * TOL + 6)),
                  EXP - TOL - 3 + int'($urandom_range(0, 2 * TOL + 6))};
        foreach (steps[k]) begin
            s = steps[k];
            d = s - EXP;
            ok = (d < 0 ? -d : d) <= TOL;
            pll_locked = 1'b1;
            mon_step = s;
            do_reset();
            wait_state(3'd3, ACQ + 20, n);
            checks++; if (n !== ACQ) begin failures++; $display("FAIL freq_acq[%0d]: got %0d want %0d", s, n, ACQ); end
            wait_change(WIN + 10, n);
            checks++; if (n !== WIN) begin failures++; $display("FAIL freq_window[%0d]: got %0d want %0d", s, n, WIN); end
            checks++; if (obs() !== (ok ? expv(3'd4, 2'd0) : expv(3'd0, 2'd1))) begin failures++; $display("FAIL freq_verdict[%0d]: got %b want %b", s, obs(), ok ? expv(3'd4, 2'd0) : expv(3'd0, 2'd1)); end
        end
    endtask

    task automatic test_check_lockloss();
        int n, t;
        for (int v = 0; v < 3; v++) begin
            pll_locked = 1'b1;
            mon_step = EXP;
            do_reset();
            wait_state(3'd3, ACQ + 20, n);
            t = (v == 0) ? int'($urandom_range(1, WIN - 10)) : WIN - 4 + v;
            repeat (t) tick();
            pll_locked = 1'b0;
            wait_change(10, n);
            checks++; if (n !== (v == 2 ? 2 : 3)) begin failures++; $display("FAIL chk_loss_lat[%0d]: got %0d want %0d", v, n, v == 2 ? 2 : 3); end
            checks++; if (obs() !== (v == 2 ? expv(3'd4, 2'd0) : expv(3'd0, 2'd1))) begin failures++; $display("FAIL chk_loss_state[%0d]: got %b want %b", v, obs(), v == 2 ? expv(3'd4, 2'd0) : expv(3'd0, 2'd1)); end
            if (v == 2) begin
                wait_change(10, n);
                checks++; if (obs() !== expv(3'd0, 2'd0) || n !== 1) begin failures++; $display("FAIL chk_loss_run: got %b/%0d want %b/1", obs(), n, expv(3'd0, 2'd0)); end
            end
        end
    endtask

    task automatic test_glitch_stable();
        int n, g;
        pll_locked = 1'b0;
        mon_step = EXP;
        do_reset();
        wait_state(3'd1, 100, n);
        repeat (10) tick();
        pll_locked = 1'b1;
        wait_state(3'd2, 10, n);
        g = int'($urandom_range(5, SC - 10));
        repeat (g) tick();
        pll_locked = 1'b0;
        wait_change(10, n);
        checks++; if (n !== 3) begin failures++; $display("FAIL glitch_latency: got %0d want %0d", n, 3); end
        checks++; if (obs() !== expv(3'd1, 2'd0)) begin failures++; $display("FAIL glitch_wait: got %b want %b", obs(), expv(3'd1, 2'd0)); end
        repeat (2) tick();
        pll_locked = 1'b1;
        wait_state(3'd2, 10, n);
        checks++; if (n !== 3) begin failures++; $display("FAIL glitch_relock: got %0d want %0d", n, 3); end
        wait_state(3'd3, SC + 10, n);
        checks++; if (n !== SC) begin failures++; $display("FAIL glitch_full_stable: got %0d want %0d", n, SC); end
        wait_state(3'd4, WIN + 10, n);
        checks++; if (obs() !== expv(3'd4, 2'd0)) begin failures++; $display("FAIL glitch_run: got %b want %b", obs(), expv(3'd4, 2'd0)); end
    endtask

    task automatic test_run_lockloss();
        int n;
        pll_locked = 1'b1;
        mon_step = EXP;
        do_reset();
        wait_state(3'd4, ACQ + WIN + 20, n);
        checks++; if (n !== ACQ + WIN) begin failures++; $display("FAIL runloss_acq: got %0d want %0d", n, ACQ + WIN); end
        repeat ($urandom_range(1, 50)) tick();
        pll_locked = 1'b0;
        tick();
        tick();
        checks++; if (obs() !== expv(3'd4, 2'd0)) begin failures++; $display("FAIL runloss_still_run: got %b want %b", obs(), expv(3'd4, 2'd0)); end
        tick();
        checks++; if (obs() !== expv(3'd0, 2'd0)) begin failures++; $display("FAIL runloss_reset: got %b want %b", obs(), expv(3'd0, 2'd0)); end
        pll_locked = 1'b1;
        wait_state(3'd4, ACQ + WIN + 20, n);
        checks++; if (n !== ACQ + WIN) begin failures++; $display("FAIL runloss_reacq: got %0d want %0d", n, ACQ + WIN); end
        checks++; if (obs() !== expv(3'd4, 2'd0)) begin failures++; $display("FAIL runloss_run: got %b want %b", obs(), expv(3'd4, 2'd0)); end
    endtask

    task automatic test_reset_mid_check();
        int n;
        pll_locked = 1'b1;
        mon_step = 0;
        do_reset();
        wait_state(3'd3, ACQ + 20, n);
        wait_change(WIN + 10, n);
        checks++; if (obs() !== expv(3'd0, 2'd1)) begin failures++; $display("FAIL rmc_first_fail: got %b want %b", obs(), expv(3'd0, 2'd1)); end
        wait_state(3'd3, ACQ + 20, n);
        checks++; if (n !== ACQ) begin failures++; $display("FAIL rmc_second_acq: got %0d want %0d", n, ACQ); end
        repeat ($urandom_range(1, WIN - 5)) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (obs() !== expv(3'd0, 2'd0)) begin failures++; $display("FAIL rmc_reset: got %b want %b", obs(), expv(3'd0, 2'd0)); end
    endtask

    initial begin
        rst = 1'b1;
        pll_locked = 1'b0;
        test_reset();
        test_nominal();
        test_timeouts();
        test_lock_vs_timeout();
        test_freq();
        test_check_lockloss();
        test_glitch_stable();
        test_run_lockloss();
        test_reset_mid_check();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
